// File: rtl/reg_file_bypass_pkg.sv
// Shared constants, index/word types and a range helper for the bypassed register file.
package reg_file_bypass_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_NUM_REGS = 16;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_word_t;

    // True when idx names an implemented register.
    function automatic logic idx_legal(input logic [31:0] idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/reg_file_bypass_if.sv
// Decode/writeback-side bus of the register file: write port, two read ports, scoreboard.
interface reg_file_bypass_if
    import reg_file_bypass_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_en1;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              rd_busy1;

    logic              rd_en2;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy2;

    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en1, rd_addr1, rd_en2, rd_addr2,
        output busy_set, busy_addr,
        input  rd_data1, rd_busy1, rd_data2, rd_busy2, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en1, rd_addr1, rd_en2, rd_addr2,
        input  busy_set, busy_addr,
        output rd_data1, rd_busy1, rd_data2, rd_busy2, busy_cnt
    );

endinterface

// File: rtl/reg_file_bypass_reg_word.sv
// One register-file word: W-bit enable flop, async active-high reset to zero.
module reg_word #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_bypass.sv
// Register file: one write port, two combinational read ports with write-to-read
// bypass, and a per-register busy scoreboard with a registered population count.
// Optional: define REG_ZERO_HARDWIRED_EN to make index 0 a constant-zero register.
module reg_file_bypass
    import reg_file_bypass_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input logic             clk,
    input logic             rst,
    reg_file_bypass_if.slave bus
);

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit ZERO_HW = 1'b1;
`else
    localparam bit ZERO_HW = 1'b0;
`endif

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   words [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    busy_cnt_q;
    logic                wr_ok;
    logic                set_ok;

    // Qualified write / scoreboard-set strobes: illegal and hardwired-zero targets drop out here.
    assign wr_ok  = bus.wr_en && idx_legal(32'(bus.wr_addr), NUM_REGS)
                    && !(ZERO_HW && (bus.wr_addr == '0));
    assign set_ok = bus.busy_set && idx_legal(32'(bus.busy_addr), NUM_REGS)
                    && !(ZERO_HW && (bus.busy_addr == '0));

    // Storage: one enable flop word per implemented register.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        if (ZERO_HW && (i == 0)) begin : g_zero
            assign words[i] = '0;
        end else begin : g_flop
            reg_word #(.W(DATA_W)) u_word (
                .clk (clk),
                .rst (rst),
                .en  (wr_ok && (bus.wr_addr == ADDR_W'(i))),
                .d   (bus.wr_data),
                .q   (words[i])
            );
        end
    end

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];

    assign rd_en[0]   = bus.rd_en1;
    assign rd_en[1]   = bus.rd_en2;
    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    // Read ports: storage mux with same-cycle bypass, gated to zero when disabled or out of range.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] data;
        logic              busy_o;
        logic              rd_ok;
        logic              wr_hit;

        assign rd_ok  = idx_legal(32'(rd_addr[p]), NUM_REGS);
        assign wr_hit = bus.wr_en && (bus.wr_addr == rd_addr[p]);

        // Select bypass or stored word and qualify the busy hazard.
        always_comb begin
            data   = '0;
            busy_o = 1'b0;
            if (rd_en[p] && rd_ok) begin
                if (wr_ok && wr_hit) begin
                    data = bus.wr_data;
                end else begin
                    data = words[rd_addr[p]];
                end
                busy_o = busy[rd_addr[p]] && !wr_hit;
            end
        end
    end

    assign bus.rd_data1 = g_rd[0].data;
    assign bus.rd_busy1 = g_rd[0].busy_o;
    assign bus.rd_data2 = g_rd[1].data;
    assign bus.rd_busy2 = g_rd[1].busy_o;

    // Next scoreboard: writeback clears, issue sets; set applied last so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[bus.busy_addr] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    // Scoreboard and its population count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

endmodule
